// File: rtl/tennis_pkg.sv
// rtl/tennis_pkg.sv - shared score encodings, set constants and set-rule helpers
package tennis_pkg;

    typedef enum logic [1:0] {
        P0  = 2'd0,
        P15 = 2'd1,
        P30 = 2'd2,
        P40 = 2'd3
    } point_t;

    typedef enum logic [1:0] {
        ADV_NONE = 2'b00,
        ADV_P1   = 2'b01,
        ADV_P2   = 2'b10
    } adv_t;

    localparam logic [2:0] GAMES_TO_SET = 3'd6;
    localparam logic [2:0] GAMES_MAX    = 3'd7;
    localparam logic [2:0] MIN_LEAD     = 3'd2;

    function automatic logic [2:0] games_inc(input logic [2:0] g);
        return (g == GAMES_MAX) ? g : g + 3'd1;
    endfunction

    // Widened to 4 bits so opponent+lead cannot wrap at 6 or 7 games.
    function automatic logic set_won(input logic [2:0] winner_games,
                                     input logic [2:0] other_games);
        logic [3:0] need;
        need = {1'b0, other_games} + {1'b0, MIN_LEAD};
        return (winner_games == GAMES_MAX) ||
               ((winner_games >= GAMES_TO_SET) && ({1'b0, winner_games} >= need));
    endfunction

endpackage

// File: rtl/adv_tracker.sv
// rtl/adv_tracker.sv - deuce/advantage state machine for one game
module adv_tracker
    import tennis_pkg::*;
(
    input  logic       clk,
    input  logic       rs_n,
    input  logic       en,
    input  logic       p1,
    input  logic       p2,
    input  logic       clr,
    output logic [1:0] adv,
    output logic       win_p1,
    output logic       win_p2
);

    adv_t adv_q;
    logic pt1;
    logic pt2;

    assign pt1 = en & p1 & ~p2;
    assign pt2 = en & p2 & ~p1;

    always_ff @(posedge clk) begin
        if (!rs_n) begin
            adv_q <= ADV_NONE;
        end else if (clr) begin
            adv_q <= ADV_NONE;
        end else if (pt1) begin
            case (adv_q)
                ADV_NONE: adv_q <= ADV_P1;
                ADV_P1:   adv_q <= ADV_NONE;
                ADV_P2:   adv_q <= ADV_NONE;
                default:  adv_q <= ADV_NONE;
            endcase
        end else if (pt2) begin
            case (adv_q)
                ADV_NONE: adv_q <= ADV_P2;
                ADV_P1:   adv_q <= ADV_NONE;
                ADV_P2:   adv_q <= ADV_NONE;
                default:  adv_q <= ADV_NONE;
            endcase
        end
    end

    // Win pulses are decoded from the held state so the top can close the game on this same edge.
    assign win_p1 = pt1 & (adv_q == ADV_P1);
    assign win_p2 = pt2 & (adv_q == ADV_P2);
    assign adv    = adv_q;

endmodule

// File: rtl/tennis_set_ctrl.sv
// rtl/tennis_set_ctrl.sv - point, game, server and set scoring for one tennis set
module tennis_set_ctrl
    import tennis_pkg::*;
(
    input  logic       clk,
    input  logic       rs_n,
    input  logic       p1,
    input  logic       p2,
    output logic [1:0] pts1,
    output logic [1:0] pts2,
    output logic [1:0] adv,
    output logic       deuce_act,
    output logic [2:0] games1,
    output logic [2:0] games2,
    output logic       server,
    output logic       game_won,
    output logic       game_winner,
    output logic       set_done,
    output logic       set_winner
);

    point_t     pts1_q, pts1_d;
    point_t     pts2_q, pts2_d;
    logic       deuce_act_q, deuce_act_d;
    logic [2:0] games1_q, games1_d;
    logic [2:0] games2_q, games2_d;
    logic       server_q, server_d;
    logic       game_won_q, game_won_d;
    logic       game_winner_q, game_winner_d;
    logic       set_done_q, set_done_d;
    logic       set_winner_q, set_winner_d;

    logic       pt1, pt2;
    logic       trk_win_p1, trk_win_p2;
    logic       win1, win2, game_done;
    logic [1:0] trk_adv;

    // A frozen set swallows every point before it reaches any counter.
    assign pt1 = p1 & ~p2 & ~set_done_q;
    assign pt2 = p2 & ~p1 & ~set_done_q;

    adv_tracker u_adv_tracker (
        .clk    (clk),
        .rs_n   (rs_n),
        .en     (deuce_act_q),
        .p1     (pt1),
        .p2     (pt2),
        .clr    (game_done),
        .adv    (trk_adv),
        .win_p1 (trk_win_p1),
        .win_p2 (trk_win_p2)
    );

    always_comb begin
        win1 = 1'b0;
        win2 = 1'b0;
        if (deuce_act_q) begin
            win1 = trk_win_p1;
            win2 = trk_win_p2;
        end else begin
            win1 = pt1 && (pts1_q == P40);
            win2 = pt2 && (pts2_q == P40);
        end
        game_done = win1 | win2;
    end

    always_comb begin
        pts1_d        = pts1_q;
        pts2_d        = pts2_q;
        deuce_act_d   = deuce_act_q;
        games1_d      = games1_q;
        games2_d      = games2_q;
        server_d      = server_q;
        game_won_d    = 1'b0;
        game_winner_d = game_winner_q;
        set_done_d    = set_done_q;
        set_winner_d  = set_winner_q;

        if (game_done) begin
            pts1_d        = P0;
            pts2_d        = P0;
            deuce_act_d   = 1'b0;
            server_d      = ~server_q;
            game_won_d    = 1'b1;
            game_winner_d = win2;
            if (win1) begin
                games1_d = games_inc(games1_q);
                if (set_won(games1_d, games2_q)) begin
                    set_done_d   = 1'b1;
                    set_winner_d = 1'b0;
                end
            end else begin
                games2_d = games_inc(games2_q);
                if (set_won(games2_d, games1_q)) begin
                    set_done_d   = 1'b1;
                    set_winner_d = 1'b1;
                end
            end
        end else if (!deuce_act_q) begin
            if (pt1) begin
                pts1_d = point_t'(pts1_q + 2'd1);
            end
            if (pt2) begin
                pts2_d = point_t'(pts2_q + 2'd1);
            end
            deuce_act_d = (pts1_d == P40) && (pts2_d == P40);
        end
    end

    always_ff @(posedge clk) begin
        if (!rs_n) begin
            pts1_q        <= P0;
            pts2_q        <= P0;
            deuce_act_q   <= 1'b0;
            games1_q      <= 3'd0;
            games2_q      <= 3'd0;
            server_q      <= 1'b0;
            game_won_q    <= 1'b0;
            game_winner_q <= 1'b0;
            set_done_q    <= 1'b0;
            set_winner_q  <= 1'b0;
        end else begin
            pts1_q        <= pts1_d;
            pts2_q        <= pts2_d;
            deuce_act_q   <= deuce_act_d;
            games1_q      <= games1_d;
            games2_q      <= games2_d;
            server_q      <= server_d;
            game_won_q    <= game_won_d;
            game_winner_q <= game_winner_d;
            set_done_q    <= set_done_d;
            set_winner_q  <= set_winner_d;
        end
    end

    assign pts1        = pts1_q;
    assign pts2        = pts2_q;
    assign adv         = trk_adv;
    assign deuce_act   = deuce_act_q;
    assign games1      = games1_q;
    assign games2      = games2_q;
    assign server      = server_q;
    assign game_won    = game_won_q;
    assign game_winner = game_winner_q;
    assign set_done    = set_done_q;
    assign set_winner  = set_winner_q;

endmodule

// File: tb/tb_tennis_set_ctrl.sv
// tb/tb_tennis_set_ctrl.sv - scoreboard bench for tennis_set_ctrl
module tb_tennis_set_ctrl;

    logic       clk  = 1'b0;
    logic       rs_n = 1'b0;
    logic       p1   = 1'b0;
    logic       p2   = 1'b0;
    logic [1:0] pts1, pts2, adv;
    logic       deuce_act;
    logic [2:0] games1, games2;
    logic       server, game_won, game_winner, set_done, set_winner;

    tennis_set_ctrl dut (
        .clk         (clk),
        .rs_n        (rs_n),
        .p1          (p1),
        .p2          (p2),
        .pts1        (pts1),
        .pts2        (pts2),
        .adv         (adv),
        .deuce_act   (deuce_act),
        .games1      (games1),
        .games2      (games2),
        .server      (server),
        .game_won    (game_won),
        .game_winner (game_winner),
        .set_done    (set_done),
        .set_winner  (set_winner)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] pts1;
        logic [1:0] pts2;
        logic [1:0] adv;
        logic       deuce;
        logic [2:0] g1;
        logic [2:0] g2;
        logic       srv;
        logic       gw;
        logic       gwin;
        logic       sd;
        logic       sw;
    } snap_t;

    snap_t exp_q[$];
    snap_t mon_e, mon_a;
    int    checks = 0;
    int    errors = 0;

    // Reference score kept as raw point tallies per game.
    int   ra, rb, mg1, mg2;
    logic msrv, mgw, mgwin, msd, msw;

    function automatic snap_t model_snap();
        snap_t s;
        logic  dc;
        dc      = (ra >= 3) && (rb >= 3);
        s.pts1  = dc ? 2'd3 : 2'(ra);
        s.pts2  = dc ? 2'd3 : 2'(rb);
        s.adv   = !dc ? 2'b00 : (ra > rb) ? 2'b01 : (rb > ra) ? 2'b10 : 2'b00;
        s.deuce = dc;
        s.g1    = 3'(mg1);
        s.g2    = 3'(mg2);
        s.srv   = msrv;
        s.gw    = mgw;
        s.gwin  = mgwin;
        s.sd    = msd;
        s.sw    = msw;
        return s;
    endfunction

    task automatic model_game(input logic w);
        int wg, og;
        if (w) mg2++; else mg1++;
        ra = 0;
        rb = 0;
        msrv  = ~msrv;
        mgw   = 1'b1;
        mgwin = w;
        wg = w ? mg2 : mg1;
        og = w ? mg1 : mg2;
        if (wg == 7 || (wg == 6 && og <= 4)) begin
            msd = 1'b1;
            msw = w;
        end
    endtask

    task automatic model_step(input logic a, input logic b, input logic rst);
        if (rst) begin
            ra = 0; rb = 0; mg1 = 0; mg2 = 0;
            msrv = 0; mgw = 0; mgwin = 0; msd = 0; msw = 0;
        end else begin
            mgw = 1'b0;
            if (!msd && (a ^ b)) begin
                if (a) ra++; else rb++;
                if (ra >= 4 && ra >= rb + 2) model_game(1'b0);
                else if (rb >= 4 && rb >= ra + 2) model_game(1'b1);
            end
        end
    endtask

    task automatic step(input logic a, input logic b, input logic r);
        @(negedge clk);
        #1;
        p1   = a;
        p2   = b;
        rs_n = r;
        model_step(a, b, !r);
        exp_q.push_back(model_snap());
        @(posedge clk);
        #1;
        p1   = 1'b0;
        p2   = 1'b0;
        rs_n = 1'b1;
    endtask

    task automatic win_game(input logic who);
        repeat (4) step(!who, who, 1'b1);
    endtask

    task automatic direct(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {pts1, pts2, adv, deuce_act, games1, games2,
                     server, game_won, game_winner, set_done, set_winner};
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL scoreboard t=%0t got pts=%0d/%0d adv=%b deuce=%b games=%0d/%0d srv=%b gw=%b gwin=%b sd=%b sw=%b expected pts=%0d/%0d adv=%b deuce=%b games=%0d/%0d srv=%b gw=%b gwin=%b sd=%b sw=%b",
                         $time, mon_a.pts1, mon_a.pts2, mon_a.adv, mon_a.deuce, mon_a.g1, mon_a.g2,
                         mon_a.srv, mon_a.gw, mon_a.gwin, mon_a.sd, mon_a.sw,
                         mon_e.pts1, mon_e.pts2, mon_e.adv, mon_e.deuce, mon_e.g1, mon_e.g2,
                         mon_e.srv, mon_e.gw, mon_e.gwin, mon_e.sd, mon_e.sw);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        step(1'b0, 1'b0, 1'b0);
        direct("reset_games1", games1, 0);
        direct("reset_set_done", set_done, 0);

        // Four straight points to p1: 15, 30, 40, game.
        step(1'b1, 1'b0, 1'b1);
        direct("pts1_15", pts1, 1);
        step(1'b1, 1'b0, 1'b1);
        direct("pts1_30", pts1, 2);
        step(1'b1, 1'b0, 1'b1);
        direct("pts1_40", pts1, 3);
        step(1'b1, 1'b0, 1'b1);
        direct("game1_won", game_won, 1);
        direct("game1_games1", games1, 1);
        direct("game1_server", server, 1);
        direct("game1_pts1", pts1, 0);
        step(1'b0, 1'b0, 1'b1);
        direct("game_won_pulse_end", game_won, 0);

        // Deuce, advantage swings, then p2 takes the game.
        repeat (3) step(1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b1, 1'b1);
        direct("deuce_entry", deuce_act, 1);
        direct("deuce_adv", adv, 0);
        step(1'b1, 1'b0, 1'b1);
        direct("adv_p1", adv, 1);
        step(1'b0, 1'b1, 1'b1);
        direct("adv_back_deuce", adv, 0);
        step(1'b0, 1'b1, 1'b1);
        direct("adv_p2", adv, 2);
        step(1'b0, 1'b1, 1'b1);
        direct("deuce_game_winner", game_winner, 1);
        direct("deuce_games2", games2, 1);
        direct("deuce_cleared", deuce_act, 0);

        // Simultaneous strobes change nothing.
        step(1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b1, 1'b1);
        direct("both_high_pts1", pts1, 1);
        repeat (3) step(1'b1, 1'b0, 1'b1);

        // 6-6 then p2 takes the tie-deciding game; later points are ignored.
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            win_game(1'b0);
            win_game(1'b1);
        end
        direct("six_all_no_set", set_done, 0);
        win_game(1'b1);
        direct("seven_games2", games2, 7);
        direct("seven_set_done", set_done, 1);
        direct("seven_set_winner", set_winner, 1);
        repeat (4) step(1'b1, 1'b0, 1'b1);
        direct("frozen_pts1", pts1, 0);
        direct("frozen_games1", games1, 6);

        // 6-4 closes the set for p1.
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            win_game(1'b0);
            win_game(1'b1);
        end
        win_game(1'b0);
        direct("five_four_open", set_done, 0);
        win_game(1'b0);
        direct("six_four_done", set_done, 1);
        direct("six_four_winner", set_winner, 0);

        // 6-5 stays open; 7-5 closes.
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            win_game(1'b0);
            win_game(1'b1);
        end
        win_game(1'b0);
        direct("six_five_open", set_done, 0);
        win_game(1'b0);
        direct("seven_five_games1", games1, 7);
        direct("seven_five_done", set_done, 1);

        // Reset on the edge that would have won the game from advantage p1.
        step(1'b0, 1'b0, 1'b0);
        win_game(1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        direct("pre_reset_adv", adv, 1);
        step(1'b1, 1'b0, 1'b0);
        direct("reset_no_game_won", game_won, 0);
        direct("reset_games1_mid", games1, 0);
        direct("reset_adv_mid", adv, 0);
        step(1'b0, 1'b0, 1'b1);

        @(negedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
